cla_share_arbiter: RTL and testbench
====================================

Name: cla_share_arbiter

Overview:
Shares one external pipelined 32-bit CLA adder (fixed latency LAT) among NUM_REQ requesters. Round-robin arbitration issues at most one add per cycle and tracks requester IDs through a tag pipeline aligned to the adder latency. Results are returned in issue order through a credit-protected response FIFO with valid/ready backpressure.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
W, 32, operand width; must match adder
LAT, 4, adder latency in clocks (inputs sampled at edge k, sum/cout valid after edge k+LAT-1)
FIFO_DEPTH, 8, response FIFO entries; must be >= LAT+1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester operation valid
req_ready  out  NUM_REQ  per-requester grant/accept
req_a  in  NUM_REQ*W  operand A, requester i at [i*W +: W]
req_b  in  NUM_REQ*W  operand B, same packing
req_cin  in  NUM_REQ  carry-in per requester
add_a  out  W  to adder A
add_b  out  W  to adder B
add_cin  out  1  to adder cin
add_sum  in  W  from adder sum
add_cout  in  1  from adder cout
rsp_valid  out  1  response available
rsp_ready  in  1  response consumer ready
rsp_id  out  clog2(NUM_REQ)  originating requester
rsp_sum  out  W  result sum
rsp_cout  out  1  result carry-out

Behaviour:
- Reset (rst=0, async): rr pointer=0, all tag stages invalid, FIFO empty, in-flight count=0; req_ready=0, rsp_valid=0, add_a/add_b/add_cin=0, rsp_id/sum/cout=0.
- credits = FIFO_DEPTH - fifo_count - inflight; issue allowed only when credits>0.
- Arbitration (combinational): scan req_valid starting at pointer, wrapping; first valid index g is granted if credits>0. req_ready[g]=1, all others 0. req_ready may depend on req_valid.
- Issue: add_a/b/cin = operands of g in the same cycle; no issue -> driven 0. At edge, pointer <= (g+1) mod NUM_REQ; unchanged when no issue.
- Tag pipe: LAT stages of {valid,id}; stage0 captures issue. Stage LAT-1 output aligns with add_sum/add_cout.
- Retire: when stage LAT-1 valid, push {id,add_sum,add_cout} into FIFO at next edge; issue-to-rsp_valid latency = LAT+1 cycles with empty FIFO.
- inflight = count of valid tag stages; increments on issue, decrements on push; both in one cycle -> unchanged.
- FIFO: rsp_* show head; pop on rsp_valid&rsp_ready. Push and pop same cycle legal incl. when full-minus-one or full-with-pop; overflow impossible by credit rule (no assertion needed, but bench checks).
- Throughput: rsp_ready held 1 -> one issue every cycle sustained.
- rsp_ready=0 -> FIFO fills; issuing stops when credits=0; resumes cycle after a pop frees credit.
- Responses strictly in issue order; arithmetic is full W-bit sum, cout = bit W.
- Reset mid-operation: in-flight tags and FIFO contents discarded; adder outputs arriving after reset never pushed.

Optional Feature:
CLA_ARB_PERF_EN: adds output perf_grants (NUM_REQ*16): per-requester saturating 16-bit grant counters, cleared by reset, increment on each issue to that requester, hold at 16'hFFFF. Without macro: port and counters absent; behaviour otherwise identical.

Test Plan:
- Req0 only, A=32'hFFFFFFFF, B=1, cin=0 -> rsp after 5 cycles: id=0, sum=0, cout=1.
- All 4 requesters valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle; rsp_id sequence identical, sums correct.
- rsp_ready=0, all valid -> exactly 8 issues then req_ready=0; raise rsp_ready -> 8 responses in order, issuing resumes, no loss.
- Req1 and Req3 valid, pointer=2 -> Req3 granted first, then Req1, pointer ends at 2.
- Assert rst low with 3 in flight and 2 in FIFO -> rsp_valid=0 immediately; after release no stale responses appear.
- (CLA_ARB_PERF_EN) 70000 issues to Req2 -> perf_grants[2] = 16'hFFFF.

Source files
------------

// File: rtl/cla_share_arbiter_if.sv
// Requester, adder and response signal bundle for cla_share_arbiter.
// slave = arbiter side, master = requesters/adder/consumer side.
`timescale 1ns/1ps
interface cla_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int W       = 32
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*W-1:0] req_a;
  logic [NUM_REQ*W-1:0] req_b;
  logic [NUM_REQ-1:0]   req_cin;

  logic [W-1:0]         add_a;
  logic [W-1:0]         add_b;
  logic                 add_cin;
  logic [W-1:0]         add_sum;
  logic                 add_cout;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [W-1:0]         rsp_sum;
  logic                 rsp_cout;

  modport slave (
    input  req_valid, req_a, req_b, req_cin, add_sum, add_cout, rsp_ready,
    output req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport master (
    output req_valid, req_a, req_b, req_cin, add_sum, add_cout, rsp_ready,
    input  req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );
endinterface

// File: rtl/cla_share_arbiter.sv
// Round-robin sharing of one pipelined external adder with an in-order, credit-protected response FIFO.
// Optional CLA_ARB_PERF_EN adds per-requester saturating 16-bit grant counters on perf_grants.
`timescale 1ns/1ps
module cla_share_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int W          = 32,
  parameter int LAT        = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  cla_share_arbiter_if.slave bus
`ifdef CLA_ARB_PERF_EN
  ,
  output logic [NUM_REQ*16-1:0] perf_grants
`endif
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW  = IDW + W + 1;

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] grant_idx;
  logic           grant_found;
  logic           issue;

  logic [CW-1:0]  fifo_count;
  logic [CW-1:0]  inflight;
  logic [CW-1:0]  credits;

  logic [LAT-1:0] tag_valid;
  logic [IDW-1:0] tag_id [LAT];

  logic           push;
  logic           pop;
  logic           fifo_nonempty;
  logic [EW-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [EW-1:0]  head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // Every issued op owns a FIFO slot from issue until it is popped, so the FIFO can never overflow.
  assign credits       = CW'(FIFO_DEPTH) - fifo_count - inflight;
  assign push          = tag_valid[LAT-1];
  assign fifo_nonempty = (fifo_count != '0);
  assign pop           = fifo_nonempty & bus.rsp_ready;
  assign head          = fifo_mem[rd_ptr];

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Reset is folded in so nothing is granted while the block is held in reset.
  assign issue = rst & grant_found & (credits != '0);

  always_comb begin
    bus.req_ready = '0;
    bus.add_a     = '0;
    bus.add_b     = '0;
    bus.add_cin   = 1'b0;
    if (issue) begin
      bus.req_ready[grant_idx] = 1'b1;
      bus.add_a   = bus.req_a[grant_idx*W +: W];
      bus.add_b   = bus.req_b[grant_idx*W +: W];
      bus.add_cin = bus.req_cin[grant_idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  // Tag stage LAT-1 lines up with the adder's sum/cout for the same operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_valid <= '0;
      for (int k = 0; k < LAT; k++) tag_id[k] <= '0;
    end else begin
      tag_valid[0] <= issue;
      tag_id[0]    <= grant_idx;
      for (int k = 1; k < LAT; k++) begin
        tag_valid[k] <= tag_valid[k-1];
        tag_id[k]    <= tag_id[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= '0;
    end else if (issue && !push) begin
      inflight <= inflight + 1'b1;
    end else if (!issue && push) begin
      inflight <= inflight - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (!push && pop) fifo_count <= fifo_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {tag_id[LAT-1], bus.add_sum, bus.add_cout};
  end

  // Storage is not reset, so the head is masked whenever the FIFO is empty.
  always_comb begin
    bus.rsp_valid = fifo_nonempty;
    bus.rsp_id    = '0;
    bus.rsp_sum   = '0;
    bus.rsp_cout  = 1'b0;
    if (fifo_nonempty) {bus.rsp_id, bus.rsp_sum, bus.rsp_cout} = head;
  end

`ifdef CLA_ARB_PERF_EN
  logic [15:0] grant_cnt [NUM_REQ];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
    end else if (issue && grant_cnt[grant_idx] != 16'hFFFF) begin
      grant_cnt[grant_idx] <= grant_cnt[grant_idx] + 16'd1;
    end
  end

  always_comb begin
    perf_grants = '0;
    for (int i = 0; i < NUM_REQ; i++) perf_grants[i*16 +: 16] = grant_cnt[i];
  end
`endif
endmodule

// File: tb/tb_cla_share_arbiter.sv
// Directed bench for cla_share_arbiter with a behavioural LAT-stage adder model.
`timescale 1ns/1ps
module tb_cla_share_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int W          = 32;
  localparam int LAT        = 4;
  localparam int FIFO_DEPTH = 8;

  typedef struct {
    int unsigned id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_miss = 0;
  int   exp_q[$];

  logic [W-1:0] op_a    [NUM_REQ];
  logic [W-1:0] op_b    [NUM_REQ];
  logic         op_cin  [NUM_REQ];
  logic [W-1:0] exp_sum [NUM_REQ];
  logic         exp_cout[NUM_REQ];
  vec_t         vecs[7];

  always #5 clk = ~clk;

  cla_share_arbiter_if #(.NUM_REQ(NUM_REQ), .W(W)) bus ();

`ifdef CLA_ARB_PERF_EN
  logic [NUM_REQ*16-1:0] perf_grants;
`endif

  cla_share_arbiter #(
    .NUM_REQ(NUM_REQ), .W(W), .LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef CLA_ARB_PERF_EN
    , .perf_grants(perf_grants)
`endif
  );

  // External adder: operands sampled at edge k, result visible after edge k+LAT-1.
  logic [W:0] add_pipe [LAT];
  always_ff @(posedge clk) begin
    add_pipe[0] <= {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{W{1'b0}}, bus.add_cin};
    for (int i = 1; i < LAT; i++) add_pipe[i] <= add_pipe[i-1];
  end
  assign bus.add_sum  = add_pipe[LAT-1][W-1:0];
  assign bus.add_cout = add_pipe[LAT-1][W];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [NUM_REQ-1:0] valid, input logic rdy);
    @(negedge clk);
    bus.req_valid = valid;
    bus.rsp_ready = rdy;
    #1;
  endtask

  task automatic set_op(input int unsigned id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    bus.req_a[id*W +: W] = a;
    bus.req_b[id*W +: W] = b;
    bus.req_cin[id]      = cin;
  endtask

  task automatic monitor_rsp();
    int exp_id;
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        check_output("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
      end else begin
        exp_id = exp_q.pop_front();
        check_output("rsp_id",   64'(bus.rsp_id),   64'(exp_id));
        check_output("rsp_sum",  64'(bus.rsp_sum),  64'(exp_sum[exp_id]));
        check_output("rsp_cout", 64'(bus.rsp_cout), 64'(exp_cout[exp_id]));
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int exp_ptr;
    int issues;

    vecs[0] = '{0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
    vecs[1] = '{1, 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0};
    vecs[2] = '{2, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
    vecs[3] = '{3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[4] = '{1, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0};
    vecs[5] = '{2, 32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 32'hDEAD_BEF0, 1'b0};
    vecs[6] = '{3, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0};

    op_a[0] = 32'hFFFF_FFFF; op_b[0] = 32'h0000_0001; op_cin[0] = 1'b0; exp_sum[0] = 32'h0000_0000; exp_cout[0] = 1'b1;
    op_a[1] = 32'h0000_0001; op_b[1] = 32'hFFFF_FFFF; op_cin[1] = 1'b1; exp_sum[1] = 32'h0000_0001; exp_cout[1] = 1'b1;
    op_a[2] = 32'h1234_5678; op_b[2] = 32'h8765_4321; op_cin[2] = 1'b1; exp_sum[2] = 32'h9999_999A; exp_cout[2] = 1'b0;
    op_a[3] = 32'h8000_0000; op_b[3] = 32'h8000_0000; op_cin[3] = 1'b0; exp_sum[3] = 32'h0000_0000; exp_cout[3] = 1'b1;

    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_op(i, op_a[i], op_b[i], op_cin[i]);

    // Reset state with every requester asking
    #3;
    check_output("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check_output("rst_add_a",     64'(bus.add_a),     64'd0);
    check_output("rst_add_cin",   64'(bus.add_cin),   64'd0);
    check_output("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_output("rst_rsp_id",    64'(bus.rsp_id),    64'd0);
    check_output("rst_rsp_sum",   64'(bus.rsp_sum),   64'd0);
    check_output("rst_rsp_cout",  64'(bus.rsp_cout),  64'd0);
    @(negedge clk);
    bus.req_valid = '0;
    rst = 1'b1;

    // Table-driven single operations: issue, exact LAT+1 latency, result, pop
    for (int v = 0; v < 7; v++) begin
      set_op(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].cin);
      apply_stimulus(4'(1 << vecs[v].id), 1'b1);
      check_output("vec_ready",   64'(bus.req_ready), 64'(1 << vecs[v].id));
      check_output("vec_add_a",   64'(bus.add_a),     64'(vecs[v].a));
      check_output("vec_add_cin", 64'(bus.add_cin),   64'(vecs[v].cin));
      repeat (4) apply_stimulus(4'h0, 1'b1);
      check_output("vec_early_valid", 64'(bus.rsp_valid), 64'd0);
      apply_stimulus(4'h0, 1'b1);
      check_output("vec_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      check_output("vec_rsp_id",    64'(bus.rsp_id),    64'(vecs[v].id));
      check_output("vec_rsp_sum",   64'(bus.rsp_sum),   64'(vecs[v].exp_sum));
      check_output("vec_rsp_cout",  64'(bus.rsp_cout),  64'(vecs[v].exp_cout));
      apply_stimulus(4'h0, 1'b1);
      check_output("vec_popped", 64'(bus.rsp_valid), 64'd0);
    end

    // All requesters continuously valid: one grant per cycle, responses in issue order
    for (int i = 0; i < NUM_REQ; i++) set_op(i, op_a[i], op_b[i], op_cin[i]);
    for (int k = 0; k < 22; k++) begin
      apply_stimulus((k < 16) ? 4'hF : 4'h0, 1'b1);
      if (k < 16) begin
        check_output("rr_grant", 64'(bus.req_ready), 64'(1 << (k % 4)));
        check_output("rr_add_a", 64'(bus.add_a),     64'(op_a[k % 4]));
        exp_q.push_back(k % 4);
      end
      if (k >= 5 && k <= 20) check_output("throughput_valid", 64'(bus.rsp_valid), 64'd1);
      if (k == 21)           check_output("rr_drained",       64'(bus.rsp_valid), 64'd0);
      monitor_rsp();
    end
    check_output("rr_all_returned", 64'(exp_q.size()), 64'd0);

    // Backpressure: exactly FIFO_DEPTH issues, then stall until a pop frees a credit
    for (int i = 0; i < 14; i++) begin
      apply_stimulus(4'hF, 1'b0);
      check_output("bp_grant", 64'(bus.req_ready), (i < 8) ? 64'(1 << (i % 4)) : 64'd0);
      if (i < 8) exp_q.push_back(i % 4);
    end
    exp_ptr = 0;
    issues  = 0;
    apply_stimulus(4'hF, 1'b1);
    check_output("bp_still_stalled", 64'(bus.req_ready), 64'd0);
    monitor_rsp();
    for (int j = 0; j < 30; j++) begin
      apply_stimulus((j < 10) ? 4'hF : 4'h0, 1'b1);
      if (j == 0) check_output("bp_resume", 64'(bus.req_ready != '0), 64'd1);
      if (bus.req_ready != '0) begin
        check_output("bp_resume_grant", 64'(bus.req_ready), 64'(1 << exp_ptr));
        exp_q.push_back(exp_ptr);
        exp_ptr = (exp_ptr + 1) % NUM_REQ;
        issues++;
      end
      monitor_rsp();
    end
    check_output("bp_resume_issues", 64'(issues), 64'd10);
    check_output("bp_no_loss", 64'(exp_q.size()), 64'd0);

    // Pointer wrap: move pointer to 2, then Req1 and Req3 contend
    apply_stimulus(4'b0010, 1'b1);
    check_output("ptr_setup", 64'(bus.req_ready), 64'b0010);
    exp_q.push_back(1);
    apply_stimulus(4'b1010, 1'b1);
    check_output("ptr_first_req3", 64'(bus.req_ready), 64'b1000);
    exp_q.push_back(3);
    monitor_rsp();
    apply_stimulus(4'b1010, 1'b1);
    check_output("ptr_then_req1", 64'(bus.req_ready), 64'b0010);
    exp_q.push_back(1);
    monitor_rsp();
    apply_stimulus(4'hF, 1'b1);
    check_output("ptr_ends_at_2", 64'(bus.req_ready), 64'b0100);
    exp_q.push_back(2);
    monitor_rsp();
    repeat (8) begin
      apply_stimulus(4'h0, 1'b1);
      monitor_rsp();
    end
    check_output("ptr_all_returned", 64'(exp_q.size()), 64'd0);

    // Reset mid-operation with 3 in flight and 2 in the FIFO
    repeat (5) apply_stimulus(4'hF, 1'b0);
    repeat (2) apply_stimulus(4'h0, 1'b0);
    check_output("pre_reset_valid", 64'(bus.rsp_valid), 64'd1);
    bus.req_valid = 4'hF;
    rst = 1'b0;
    #1;
    check_output("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_output("midrst_req_ready", 64'(bus.req_ready), 64'd0);
    check_output("midrst_add_a",     64'(bus.add_a),     64'd0);
    check_output("midrst_rsp_sum",   64'(bus.rsp_sum),   64'd0);
    repeat (3) begin
      apply_stimulus(4'hF, 1'b1);
      check_output("inrst_req_ready", 64'(bus.req_ready), 64'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    #1;
    repeat (10) begin
      apply_stimulus(4'h0, 1'b1);
      check_output("no_stale_rsp", 64'(bus.rsp_valid), 64'd0);
    end
    apply_stimulus(4'hF, 1'b1);
    check_output("post_rst_ptr0", 64'(bus.req_ready), 64'b0001);
    exp_q.push_back(0);
    repeat (7) begin
      apply_stimulus(4'h0, 1'b1);
      monitor_rsp();
    end
    check_output("post_rst_returned", 64'(exp_q.size()), 64'd0);

`ifdef CLA_ARB_PERF_EN
    // Grant counters since the last reset, then saturation of Req2
    check_output("perf_req0", 64'(perf_grants[0 +: 16]),  64'd1);
    check_output("perf_req1", 64'(perf_grants[16 +: 16]), 64'd0);
    repeat (70000) apply_stimulus(4'b0100, 1'b1);
    apply_stimulus(4'h0, 1'b1);
    check_output("perf_req2_sat", 64'(perf_grants[32 +: 16]), 64'hFFFF);
    check_output("perf_req0_hold", 64'(perf_grants[0 +: 16]), 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
